// File: rtl/reg_bank_ctr.sv
// reg_bank_ctr: bank of loadable up/down counters sharing one write bus,
// with sticky wrap flags, two indexed read ports and a flat view.
module reg_bank_ctr #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int SELW  = (COUNT > 1) ? $clog2(COUNT) : 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              data,
  input  logic [COUNT-1:0]              LDR,
  input  logic [COUNT-1:0]              INC,
  input  logic [COUNT-1:0]              DEC,
  input  logic [SELW-1:0]               ra_sel,
  input  logic [SELW-1:0]               rb_sel,
  output logic [COUNT-1:0][WIDTH-1:0]   R,
  output logic [WIDTH-1:0]              RA,
  output logic [WIDTH-1:0]              RB,
  output logic [COUNT-1:0]              WRAP
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [COUNT-1:0][WIDTH-1:0] r_q, r_d;
  logic [COUNT-1:0]            wrap_q, wrap_d;
  logic [COUNT-1:0]            up, dn;

  // Load wins; INC and DEC together cancel to a hold.
  assign up = ~LDR & INC & ~DEC;
  assign dn = ~LDR & DEC & ~INC;

  always_comb begin
    r_d    = r_q;
    wrap_d = wrap_q;
    for (int i = 0; i < COUNT; i++) begin
      unique case (1'b1)
        LDR[i]: begin
          r_d[i]    = data;
          wrap_d[i] = 1'b0;
        end
        up[i]: begin
          r_d[i]    = r_q[i] + STEP;
          wrap_d[i] = wrap_q[i] | (r_q[i] == ONES);
        end
        dn[i]: begin
          r_d[i]    = r_q[i] - STEP;
          wrap_d[i] = wrap_q[i] | (r_q[i] == ZERO);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= {COUNT{RESET_VAL}};
      wrap_q <= '0;
    end else begin
      r_q    <= r_d;
      wrap_q <= wrap_d;
    end
  end

  // Out-of-range selects match no register and read as zero.
  always_comb begin
    RA = '0;
    RB = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (ra_sel == SELW'(i)) RA = r_q[i];
      if (rb_sel == SELW'(i)) RB = r_q[i];
    end
  end

  assign R    = r_q;
  assign WRAP = wrap_q;

endmodule
